can_rx_frontend: RTL and testbench
==================================

# can_rx_frontend

CAN receive front end for the 100 MHz fabric clock at 1 Mbit/s (100 time quanta per bit). It synchronises the raw RX pin and recovers bit timing with hard sync and resynchronisation. It samples once per bit and removes stuff bits, delivering destuffed bits with a bit-stuff error flag. It sits between the transceiver pin and the frame decoder.

## Interface
- QUANTA_PER_BIT, 100: clock periods (quanta) per nominal bit.
- SAMPLE_POINT, 75: quantum index of the sample point (1 .. QUANTA_PER_BIT-2).
- clk  in  1  fabric clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-high.
- rx_raw  in  1  CAN RX pin; 1 is recessive.
- RJW  in  7  resynchronisation jump width, in quanta; 0 disables resync.
- bus_idle  in  1  high while the bus is idle; enables hard sync.
- stuff_bypass  in  1  high disables destuffing and clears the run counter.
- rx  out  1  bit value latched at the sample point.
- updated_sample  out  1  one-cycle strobe when rx is updated.
- updated_bit  out  1  one-cycle strobe: next_bit holds a valid destuffed bit.
- next_bit  out  1  destuffed data bit.
- stuff_error  out  1  one-cycle strobe: six equal consecutive bits.

## Operation
- rx_raw passes through a 2-flop synchroniser; edge detect compares against the previous synchronised value.
- Only recessive→dominant (1→0) edges are synchronisation edges.
- Quantum counter q runs 0..QUANTA_PER_BIT-1 and wraps to 0. q=0 is the sync segment.
- Hard sync: with bus_idle=1, an edge sets q so that the edge cycle is quantum 0 (q becomes 1 on the next cycle). Pending adjustments are discarded.
- Resync: with bus_idle=0, at most one edge per bit, applied to edges with q≠0.
  - 0<q≤SAMPLE_POINT is a late edge: phase error e=q. The current bit is lengthened by min(e,RJW) quanta, which delays the sample point.
  - q>SAMPLE_POINT is an early edge: e=QUANTA_PER_BIT−q. The current bit is shortened by min(e,RJW); the wrap to q=0 happens early, clamped so it is never before the edge cycle.
- Sample: at the (adjusted) sample point, rx takes the synchronised value and updated_sample pulses.
- Destuff, on each updated_sample with stuff_bypass=0:
  - Track the last bit value and a run count 1..5.
  - If the run count is below 5: emit the bit. Count +1 if it equals the last bit, otherwise restart at 1.
  - If the run count is 5 and the bit differs: it is a stuff bit. Do not emit it; the run restarts at 1 with the stuff bit's value.
  - If the run count is 5 and the bit is equal: pulse stuff_error, emit nothing, restart the run at 1 with that value.
- While stuff_bypass=1: every sample is emitted, the run counter is held cleared (next bit starts a new run), and stuff_error stays 0.

## Timing
- Reset values: rx=1, updated_sample=0, updated_bit=0, next_bit=1, stuff_error=0, q=0, run count=0, synchroniser flops=1.
- Pin to edge detection: 2 cycles.
- updated_sample and rx are registered on the same edge.
- updated_bit, next_bit and stuff_error are registered one cycle after updated_sample.
- updated_bit and stuff_error are never both high.
- A sync edge in the same cycle as the sample point: sample first, then apply the adjustment.
- A reset mid-bit returns all state to reset values immediately.
- stuff_bypass rising mid-run takes effect for the next sample.

## Configuration
- CAN_TRIPLE_SAMPLE_EN defined: rx is the majority of the synchronised value at quanta SAMPLE_POINT-2, SAMPLE_POINT-1 and SAMPLE_POINT; updated_sample timing is unchanged.
- CAN_TRIPLE_SAMPLE_EN undefined: single sample at SAMPLE_POINT.

## Structure
- Shared package can_pkg holds:
  - constants: QUANTA_PER_BIT default, SAMPLE_POINT default, STUFF_LIMIT=5
  - typedef for the 7-bit quantum counter
  - CAN_RECESSIVE=1
- One sub-module, sync_sample_machine: synchroniser, quantum counter, hard sync/resync and sample strobe, producing rx and updated_sample.
- The destuffer is in the top level.

## Test plan
- Pin pattern 100100100100100100100100, stuff_bypass=0, bus_idle dropped after the first edge → 24 updated_bit strobes echoing the pattern, no stuff_error.
- Pattern 100000100011111011110010 → 22 bits 1000000001111111110010 emitted; bits 7 and 16 are dropped as stuff bits; stuff_error=0.
- Same pattern with stuff_bypass=1 → all 24 bits emitted unchanged, stuff_error=0.
- Pattern 100000000011111111100000 → stuff_error pulses at the 7th bit (sixth 0) and again later at the sixth 1; no updated_bit on those samples.
- Bus idle with rx_raw=1, then 0 → updated_sample pulses at 2+SAMPLE_POINT cycles after the pin edge, then every 100 cycles.
- RJW=1, edge arriving 3 quanta late mid-frame → next sample at +101 cycles, not +103. RJW=0 → stays at +100.

Source files
------------

// File: rtl/can_pkg.sv
// Shared constants and types for the CAN receive front end.
package can_pkg;

    localparam int   QUANTA_PER_BIT_DEF = 100;
    localparam int   SAMPLE_POINT_DEF   = 75;
    localparam int   STUFF_LIMIT        = 5;
    localparam logic CAN_RECESSIVE      = 1'b1;

    typedef logic [6:0] quanta_t;
    typedef logic [2:0] run_t;

    typedef enum logic [1:0] {
        DS_EMIT,
        DS_DROP,
        DS_ERROR
    } ds_action_e;

    function automatic quanta_t min_q(input quanta_t a, input quanta_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/can_rx_frontend_if.sv
// Pin-side inputs and frame-decoder-side outputs of the CAN receive front end.
interface can_rx_frontend_if;
    import can_pkg::*;

    logic    rx_raw;
    quanta_t RJW;
    logic    bus_idle;
    logic    stuff_bypass;
    logic    rx;
    logic    updated_sample;
    logic    updated_bit;
    logic    next_bit;
    logic    stuff_error;

    modport master (
        output rx_raw, RJW, bus_idle, stuff_bypass,
        input  rx, updated_sample, updated_bit, next_bit, stuff_error
    );

    modport slave (
        input  rx_raw, RJW, bus_idle, stuff_bypass,
        output rx, updated_sample, updated_bit, next_bit, stuff_error
    );

endinterface

// File: rtl/can_rx_frontend_sync_sample_machine.sv
// RX pin synchroniser, quantum counter with hard sync / resync, and sample strobe.
// CAN_TRIPLE_SAMPLE_EN selects majority-of-three sampling instead of a single sample.
module sync_sample_machine
    import can_pkg::*;
#(
    parameter int QUANTA_PER_BIT = QUANTA_PER_BIT_DEF,
    parameter int SAMPLE_POINT   = SAMPLE_POINT_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    rx_raw,
    input  logic    bus_idle,
    input  quanta_t rjw,
    output logic    rx,
    output logic    updated_sample
);

    localparam quanta_t Q_N    = quanta_t'(QUANTA_PER_BIT);
    localparam quanta_t Q_LAST = quanta_t'(QUANTA_PER_BIT - 1);
    localparam quanta_t Q_SP   = quanta_t'(SAMPLE_POINT);

    logic       sync_1, sync_2, sync_prev;
    quanta_t    q, q_next, jump;
    logic       sampled, sampled_next, resynced, resynced_next;
    logic       edge_fall, sample_now, rx_next;
    logic [7:0] early_end;

    assign edge_fall  = sync_prev & ~sync_2;
    // A late resync at the sample point rewinds q; the flag stops a second sample.
    assign sample_now = (q == Q_SP) & ~sampled;

`ifdef CAN_TRIPLE_SAMPLE_EN
    logic early_2, early_1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            early_2 <= CAN_RECESSIVE;
            early_1 <= CAN_RECESSIVE;
        end else begin
            if (q == quanta_t'(SAMPLE_POINT - 2)) early_2 <= sync_2;
            if (q == quanta_t'(SAMPLE_POINT - 1)) early_1 <= sync_2;
        end
    end

    assign rx_next = (early_2 & early_1) | (early_2 & sync_2) | (early_1 & sync_2);
`else
    assign rx_next = sync_2;
`endif

    always_comb begin
        q_next        = (q == Q_LAST) ? '0 : q + 1'b1;
        sampled_next  = sampled | sample_now;
        resynced_next = resynced;
        jump          = '0;
        early_end     = '0;
        if (edge_fall && bus_idle) begin
            q_next        = quanta_t'(1);
            sampled_next  = 1'b0;
            resynced_next = 1'b0;
        end else if (edge_fall && !resynced && q != '0 && rjw != '0) begin
            resynced_next = 1'b1;
            if (q <= Q_SP) begin
                jump   = min_q(q, rjw);
                q_next = q + 1'b1 - jump;
            end else begin
                jump      = min_q(Q_N - q, rjw);
                early_end = {1'b0, q} + {1'b0, jump} + 8'd1;
                // Never wrap before the edge cycle itself has been counted.
                q_next    = (early_end >= {1'b0, Q_N}) ? '0 : early_end[6:0];
            end
        end
        if (q_next == '0) begin
            sampled_next  = 1'b0;
            resynced_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1         <= CAN_RECESSIVE;
            sync_2         <= CAN_RECESSIVE;
            sync_prev      <= CAN_RECESSIVE;
            q              <= '0;
            sampled        <= 1'b0;
            resynced       <= 1'b0;
            rx             <= CAN_RECESSIVE;
            updated_sample <= 1'b0;
        end else begin
            sync_1         <= rx_raw;
            sync_2         <= sync_1;
            sync_prev      <= sync_2;
            q              <= q_next;
            sampled        <= sampled_next;
            resynced       <= resynced_next;
            updated_sample <= sample_now;
            if (sample_now) rx <= rx_next;
        end
    end

endmodule

// File: rtl/can_rx_frontend.sv
// CAN receive front end: bit timing recovery plus destuffing of the sampled bits.
module can_rx_frontend
    import can_pkg::*;
#(
    parameter int QUANTA_PER_BIT = QUANTA_PER_BIT_DEF,
    parameter int SAMPLE_POINT   = SAMPLE_POINT_DEF
) (
    input logic              clk,
    input logic              rst,
    can_rx_frontend_if.slave bus
);

    logic       rx_s, updated_sample_s;
    logic       updated_bit_r, next_bit_r, stuff_error_r, last_bit;
    run_t       run_cnt;
    ds_action_e action;

    sync_sample_machine #(
        .QUANTA_PER_BIT(QUANTA_PER_BIT),
        .SAMPLE_POINT  (SAMPLE_POINT)
    ) u_sync_sample_machine (
        .clk           (clk),
        .rst           (rst),
        .rx_raw        (bus.rx_raw),
        .bus_idle      (bus.bus_idle),
        .rjw           (bus.RJW),
        .rx            (rx_s),
        .updated_sample(updated_sample_s)
    );

    always_comb begin
        action = DS_EMIT;
        if (!bus.stuff_bypass && run_cnt == run_t'(STUFF_LIMIT))
            action = (rx_s == last_bit) ? DS_ERROR : DS_DROP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt       <= '0;
            last_bit      <= CAN_RECESSIVE;
            updated_bit_r <= 1'b0;
            next_bit_r    <= CAN_RECESSIVE;
            stuff_error_r <= 1'b0;
        end else begin
            updated_bit_r <= 1'b0;
            stuff_error_r <= 1'b0;
            if (bus.stuff_bypass) run_cnt <= '0;
            if (updated_sample_s) begin
                last_bit <= rx_s;
                case (action)
                    DS_EMIT: begin
                        updated_bit_r <= 1'b1;
                        next_bit_r    <= rx_s;
                        if (!bus.stuff_bypass)
                            run_cnt <= (run_cnt != '0 && rx_s == last_bit) ?
                                       run_cnt + 1'b1 : run_t'(1);
                    end
                    DS_DROP:  run_cnt <= run_t'(1);
                    DS_ERROR: begin
                        stuff_error_r <= 1'b1;
                        run_cnt       <= run_t'(1);
                    end
                    default:  run_cnt <= '0;
                endcase
            end
        end
    end

    assign bus.rx             = rx_s;
    assign bus.updated_sample = updated_sample_s;
    assign bus.updated_bit    = updated_bit_r;
    assign bus.next_bit       = next_bit_r;
    assign bus.stuff_error    = stuff_error_r;

endmodule

// File: tb/tb_can_rx_frontend.sv
// Directed bench for can_rx_frontend: pin patterns against a bit-level model, plus resync timing.
`timescale 1ns/1ps
module tb_can_rx_frontend;
    import can_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    can_rx_frontend_if bus();
    can_rx_frontend dut (.clk(clk), .rst(rst), .bus(bus));

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    us_log[$];
    bit    chk_on   = 1'b0;
    int    c_start  = 0;
    string cur_pat  = "";
    int    pat_len  = 0;
    int    exp_ev[0:31];   // per sample: 0 none, 2 bit=0, 3 bit=1, 4 stuff error

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.updated_sample) us_log.push_back(cyc);

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int pat_bit(input int j);
        return (cur_pat[j] == "1") ? 1 : 0;
    endfunction

    // Bit-level destuffing model over the transmitted pin bits.
    task automatic build_model(input string s, input bit bypass);
        int run;
        int prev;
        int b;
        run     = 0;
        prev    = 1;
        cur_pat = s;
        pat_len = s.len();
        for (int j = 0; j < pat_len; j++) begin
            b = (s[j] == "1") ? 1 : 0;
            if (bypass) begin
                exp_ev[j] = 2 + b;
                run       = 0;
            end else if (run == STUFF_LIMIT) begin
                exp_ev[j] = (b == prev) ? 4 : 0;
                run       = 1;
            end else begin
                exp_ev[j] = 2 + b;
                run       = (run != 0 && b == prev) ? run + 1 : 1;
            end
            prev = b;
        end
    endtask

    // Per-cycle comparison against the model while a pattern is running.
    int pc, jj, exp_us, act_ev, exp_now;
    always @(negedge clk) if (chk_on) begin
        pc     = cyc - c_start;
        jj     = pc / 100;
        exp_us = (pc % 100 == 76 && jj < pat_len) ? 1 : 0;
        check("updated_sample", int'(bus.updated_sample), exp_us);
        if (exp_us == 1) check("rx_at_sample", int'(bus.rx), pat_bit(jj));
        act_ev  = bus.stuff_error ? 4 : (bus.updated_bit ? 2 + int'(bus.next_bit) : 0);
        exp_now = (pc % 100 == 77 && (pc - 77) / 100 < pat_len && pc >= 77) ?
                  exp_ev[(pc - 77) / 100] : 0;
        check("destuff_event", act_ev, exp_now);
        check("bit_and_error_exclusive", int'(bus.updated_bit & bus.stuff_error), 0);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Bit k occupies 100 cycles; bit 1 is captured on the 99th posedge after release.
    task automatic run_pattern(input string s, input bit bypass);
        build_model(s, bypass);
        bus.stuff_bypass = bypass;
        bus.bus_idle     = 1'b1;
        bus.rx_raw       = 1'b1;
        bus.RJW          = quanta_t'(4);
        do_reset();
        c_start = cyc;
        chk_on  = 1'b1;
        repeat (98) @(posedge clk);
        @(negedge clk);
        for (int k = 1; k < pat_len; k++) begin
            bus.rx_raw = (s[k] == "1");
            if (k == 1) begin
                repeat (10) @(negedge clk);
                bus.bus_idle = 1'b0;
                repeat (90) @(negedge clk);
            end else begin
                repeat (100) @(negedge clk);
            end
        end
        chk_on = 1'b0;
    endtask

    task automatic timing_test(input string name, input int rjw, input int off2,
                               input int gap2, input int gap3);
        int c0;
        bus.RJW          = quanta_t'(rjw);
        bus.bus_idle     = 1'b1;
        bus.rx_raw       = 1'b1;
        bus.stuff_bypass = 1'b1;
        do_reset();
        repeat (30) @(negedge clk);
        us_log.delete();
        bus.rx_raw = 1'b0;
        c0 = cyc + 1;
        repeat (10) @(negedge clk);
        bus.bus_idle = 1'b0;
        repeat (140) @(negedge clk);
        bus.rx_raw = 1'b1;
        repeat (off2 - 150) @(negedge clk);
        bus.rx_raw = 1'b0;
        repeat (500 - off2) @(negedge clk);
        if (us_log.size() < 4) begin
            check({name, "_pulse_count"}, us_log.size(), 4);
        end else begin
            check({name, "_first_sample"}, us_log[0] - c0, 77);
            check({name, "_gap1"}, us_log[1] - us_log[0], 100);
            check({name, "_gap2"}, us_log[2] - us_log[1], gap2);
            check({name, "_gap3"}, us_log[3] - us_log[2], gap3);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string got;
        int    errs;
        bus.rx_raw       = 1'b1;
        bus.RJW          = quanta_t'(4);
        bus.bus_idle     = 1'b1;
        bus.stuff_bypass = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #20;
        check("reset_rx", int'(bus.rx), 1);
        check("reset_updated_sample", int'(bus.updated_sample), 0);
        check("reset_updated_bit", int'(bus.updated_bit), 0);
        check("reset_next_bit", int'(bus.next_bit), 1);
        check("reset_stuff_error", int'(bus.stuff_error), 0);

        // Pin the model with hand-derived results.
        build_model("100000100011111011110010", 1'b0);
        got = "";
        for (int j = 0; j < pat_len; j++)
            if (exp_ev[j] == 2 || exp_ev[j] == 3) got = {got, (exp_ev[j] == 3) ? "1" : "0"};
        n_checks++;
        if (got != "1000000001111111110010") begin
            n_fail++;
            $display("FAIL model_destuff_bits: got %s expected 1000000001111111110010", got);
        end
        check("model_stuff_drop_bit6", exp_ev[6], 0);
        check("model_stuff_drop_bit15", exp_ev[15], 0);
        build_model("100000000011111111100000", 1'b0);
        errs = 0;
        for (int j = 0; j < pat_len; j++) if (exp_ev[j] == 4) errs++;
        check("model_error_count", errs, 2);
        check("model_error_bit6", exp_ev[6], 4);
        check("model_error_bit15", exp_ev[15], 4);

        run_pattern("100100100100100100100100", 1'b0);
        run_pattern("100000100011111011110010", 1'b0);
        run_pattern("100000100011111011110010", 1'b1);
        run_pattern("100000000011111111100000", 1'b0);

        check("end_rx_low", int'(bus.rx), 0);
        check("end_next_bit_low", int'(bus.next_bit), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midbit_reset_rx", int'(bus.rx), 1);
        check("midbit_reset_next_bit", int'(bus.next_bit), 1);
        check("midbit_reset_updated_sample", int'(bus.updated_sample), 0);

        timing_test("rjw0_late3", 0, 203, 100, 100);
        timing_test("rjw1_late3", 1, 203, 101, 100);
        timing_test("rjw5_late3", 5, 203, 103, 100);
        timing_test("rjw1_early2", 1, 298, 100, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
